// File: rtl/sync_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sync_pkg
//  Description : Shared types and constants for the short-preamble
//                synchroniser: default I/Q sample width, packed complex
//                sample type and the two standard autocorrelation lags.
//  Revision    : 1.0 - initial release
// ============================================================================
package sync_pkg;

    localparam int IQ_WIDTH_DEFAULT = 16;

    // Autocorrelation lags for the short and long training fields.
    localparam int STS_DELAY = 16;
    localparam int LTS_DELAY = 64;

    typedef struct packed {
        logic signed [IQ_WIDTH_DEFAULT-1:0] i;
        logic signed [IQ_WIDTH_DEFAULT-1:0] q;
    } iq_sample_t;

endpackage
`default_nettype wire

// File: rtl/iq_sdp_ram.sv
`default_nettype none
// ============================================================================
//  Module      : iq_sdp_ram
//  Description : Simple dual-port register-array memory. One write port, one
//                read port, read-before-write on an address collision, and a
//                registered read-data output that can be cleared.
//  Ports       : CLK      - rising-edge clock
//                a_RST_n  - asynchronous active-low reset (read register)
//                clr      - synchronous clear of the read register
//                wr_en    - write strobe; wr_addr / wr_data
//                rd_en    - read strobe; rd_addr / rd_data (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module iq_sdp_ram
    import sync_pkg::*;
#(
    parameter int DEPTH  = LTS_DELAY,
    parameter int WIDTH  = 2 * IQ_WIDTH_DEFAULT,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              a_RST_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    // Storage array carries no reset so it maps onto plain flops / LUT RAM.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read of the same array returns the pre-write contents
    // when rd_addr == wr_addr.
    always_ff @(posedge CLK or negedge a_RST_n) begin
        if (!a_RST_n) begin
            r_rd_data <= '0;
        end else if (clr) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/iq_var_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : iq_var_delay_line
//  Description : Runtime-programmable complex sample delay line. Each accepted
//                sample is written to a circular buffer and the sample
//                accepted D strobes earlier is emitted one clock later.
//                Define IQ_DELAY_CONJ_EN to emit the saturated complex
//                conjugate of the delayed sample instead.
//  Ports       : CLK        - rising-edge clock
//                a_RST_n    - asynchronous active-low reset
//                enable     - low = synchronous soft clear
//                delay_sel  - delay D (1..MAX_DELAY; 0 or larger = MAX_DELAY)
//                in_strobe  - input sample valid
//                a_i, a_q   - signed input sample
//                a_i_de, a_q_de - signed delayed sample (registered)
//                out_strobe - one pulse per accepted input
//                out_valid  - delayed sample is genuine (buffer held >= D)
//  Revision    : 1.0 - initial release
// ============================================================================
module iq_var_delay_line
    import sync_pkg::*;
#(
    parameter int IQ_WIDTH   = IQ_WIDTH_DEFAULT,
    parameter int MAX_DELAY  = LTS_DELAY,
    parameter int DSEL_WIDTH = $clog2(MAX_DELAY) + 1
) (
    input  logic                       CLK,
    input  logic                       a_RST_n,
    input  logic                       enable,
    input  logic [DSEL_WIDTH-1:0]      delay_sel,
    input  logic                       in_strobe,
    input  logic signed [IQ_WIDTH-1:0] a_i,
    input  logic signed [IQ_WIDTH-1:0] a_q,
    output logic signed [IQ_WIDTH-1:0] a_i_de,
    output logic signed [IQ_WIDTH-1:0] a_q_de,
    output logic                       out_strobe,
    output logic                       out_valid
);

    localparam int                    c_addr_w = $clog2(MAX_DELAY);
    localparam logic [DSEL_WIDTH-1:0] c_max_d  = DSEL_WIDTH'(MAX_DELAY);

    logic [c_addr_w-1:0]   r_wr_ptr;
    logic [DSEL_WIDTH-1:0] r_fill;
    logic [DSEL_WIDTH-1:0] r_prev_d;
    logic                  r_out_strobe;
    logic                  r_out_valid;

    logic                  w_accept;
    logic [DSEL_WIDTH-1:0] w_d_eff;
    logic                  w_d_change;
    logic [c_addr_w-1:0]   w_rd_addr;
    logic [2*IQ_WIDTH-1:0] w_wr_data;
    logic [2*IQ_WIDTH-1:0] w_rd_data;
    logic signed [IQ_WIDTH-1:0] w_rd_i;
    logic signed [IQ_WIDTH-1:0] w_rd_q;

    assign w_accept = enable & in_strobe;

    // Out-of-range selections fall back to the full buffer depth.
    always_comb begin
        w_d_eff = delay_sel;
        if ((delay_sel == '0) || (delay_sel > c_max_d)) begin
            w_d_eff = c_max_d;
        end
    end

    assign w_d_change = (w_d_eff != r_prev_d);

    // D = MAX_DELAY has zero low bits, so it reads the slot being written
    // this cycle and the RAM returns its old contents.
    assign w_rd_addr = r_wr_ptr - w_d_eff[c_addr_w-1:0];
    assign w_wr_data = {a_i, a_q};

    iq_sdp_ram #(
        .DEPTH  (MAX_DELAY),
        .WIDTH  (2 * IQ_WIDTH),
        .ADDR_W (c_addr_w)
    ) u_ram (
        .CLK     (CLK),
        .a_RST_n (a_RST_n),
        .clr     (~enable),
        .wr_en   (w_accept),
        .wr_addr (r_wr_ptr),
        .wr_data (w_wr_data),
        .rd_en   (w_accept),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge CLK or negedge a_RST_n) begin
        if (!a_RST_n) begin
            r_wr_ptr     <= '0;
            r_fill       <= '0;
            r_prev_d     <= c_max_d;
            r_out_strobe <= 1'b0;
            r_out_valid  <= 1'b0;
        end else if (!enable) begin
            r_wr_ptr     <= '0;
            r_fill       <= '0;
            r_prev_d     <= c_max_d;
            r_out_strobe <= 1'b0;
            r_out_valid  <= 1'b0;
        end else if (in_strobe) begin
            r_wr_ptr     <= r_wr_ptr + 1'b1;
            r_prev_d     <= w_d_eff;
            r_out_strobe <= 1'b1;
            if (w_d_change) begin
                // The new lag has only this one sample behind it.
                r_fill      <= DSEL_WIDTH'(1);
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= (r_fill >= w_d_eff);
                if (r_fill != c_max_d) begin
                    r_fill <= r_fill + 1'b1;
                end
            end
        end else begin
            r_out_strobe <= 1'b0;
            r_out_valid  <= 1'b0;
        end
    end

    assign out_strobe = r_out_strobe;
    assign out_valid  = r_out_valid;

    assign {w_rd_i, w_rd_q} = w_rd_data;
    assign a_i_de = w_rd_i;

`ifdef IQ_DELAY_CONJ_EN
    localparam logic signed [IQ_WIDTH-1:0] c_q_min = {1'b1, {(IQ_WIDTH-1){1'b0}}};
    localparam logic signed [IQ_WIDTH-1:0] c_q_max = {1'b0, {(IQ_WIDTH-1){1'b1}}};

    // Negating the most negative value would wrap; clamp to the positive rail.
    assign a_q_de = (w_rd_q == c_q_min) ? c_q_max : -w_rd_q;
`else
    assign a_q_de = w_rd_q;
`endif

endmodule
`default_nettype wire
